hybrid_angle_scheduler: RTL



---
 rtl/hybrid_angle_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hybrid_angle_scheduler.sv
// Start-up sequencing, handshaked target capture and sigma-synchronous ramping of ZVS/phi angles.
// Angles step by at most STEP per sigma event; a sigma watchdog drops the controller into FAULT.
module hybrid_angle_scheduler #(
  parameter logic signed [31:0] ZVS_INIT    = 32'sd10,
  parameter logic signed [31:0] PHI_INIT    = 32'sd0,
  parameter logic signed [31:0] ANGLE_MAX   = 32'sd90,
  parameter logic signed [31:0] STEP        = 32'sd1,
  parameter int unsigned        START_DELAY = 100,
  parameter int unsigned        TIMEOUT     = 50000
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic               i_enable,
  input  logic               i_fault_clear,
  input  logic [1:0]         i_sigma,
  input  logic               i_target_valid,
  output logic               o_target_ready,
  input  logic signed [31:0] i_ZVS_target,
  input  logic signed [31:0] i_phi_target,
  output logic signed [31:0] o_ZVS,
  output logic signed [31:0] o_phi,
  output logic               o_ctrl_resetn,
  output logic               o_locked,
  output logic               o_fault,
  output logic [1:0]         o_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STARTUP = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_FAULT   = 2'd3;

  localparam logic signed [32:0] L_STEP = {STEP[31], STEP};

  logic [1:0]         r_state;
  logic signed [31:0] r_zvs, r_phi, r_zvs_tgt, r_phi_tgt;
  logic               r_ctrl_resetn, r_fault;
  logic [31:0]        r_cnt, r_wdog;
  logic [1:0]         r_sigma_prev;

  logic w_event, w_locked, w_hs, w_timeout;

  // Differences are formed at 33 bits so extreme targets/outputs cannot wrap.
  function automatic logic signed [31:0] f_ramp(input logic signed [31:0] cur,
                                                input logic signed [31:0] tgt);
    logic signed [32:0] diff;
    diff = {tgt[31], tgt} - {cur[31], cur};
    if (diff > L_STEP)       f_ramp = cur + STEP;
    else if (diff < -L_STEP) f_ramp = cur - STEP;
    else                     f_ramp = tgt;
  endfunction

  function automatic logic signed [31:0] f_clamp(input logic signed [31:0] t);
    if (t > ANGLE_MAX)       f_clamp = ANGLE_MAX;
    else if (t < -ANGLE_MAX) f_clamp = -ANGLE_MAX;
    else                     f_clamp = t;
  endfunction

  assign w_event   = (i_sigma != r_sigma_prev);
  assign w_locked  = (r_state == S_RUN) && (r_zvs == r_zvs_tgt) && (r_phi == r_phi_tgt);
  assign w_hs      = i_target_valid && w_locked;
  assign w_timeout = !w_event && (r_wdog == TIMEOUT - 1);

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      r_state       <= S_IDLE;
      r_zvs         <= ZVS_INIT;
      r_phi         <= PHI_INIT;
      r_zvs_tgt     <= ZVS_INIT;
      r_phi_tgt     <= PHI_INIT;
      r_ctrl_resetn <= 1'b0;
      r_fault       <= 1'b0;
      r_cnt         <= '0;
      r_wdog        <= '0;
      r_sigma_prev  <= 2'b00;
    end else begin
      r_sigma_prev <= i_sigma;
      case (r_state)
        S_IDLE: begin
          r_ctrl_resetn <= 1'b0;
          if (i_enable) begin
            r_state <= S_STARTUP;
            r_cnt   <= '0;
          end
        end
        S_STARTUP: begin
          if (!i_enable) begin
            r_state   <= S_IDLE;
            r_zvs     <= ZVS_INIT;
            r_phi     <= PHI_INIT;
            r_zvs_tgt <= ZVS_INIT;
            r_phi_tgt <= PHI_INIT;
          end else if (r_cnt == START_DELAY - 1) begin
            r_state       <= S_RUN;
            r_ctrl_resetn <= 1'b1;
            r_wdog        <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // Watchdog expiry outranks a simultaneous disable.
          if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_ctrl_resetn <= 1'b0;
            r_zvs         <= ZVS_INIT;
            r_phi         <= PHI_INIT;
            r_zvs_tgt     <= ZVS_INIT;
            r_phi_tgt     <= PHI_INIT;
          end else if (!i_enable) begin
            r_state       <= S_IDLE;
            r_ctrl_resetn <= 1'b0;
            r_zvs         <= ZVS_INIT;
            r_phi         <= PHI_INIT;
            r_zvs_tgt     <= ZVS_INIT;
            r_phi_tgt     <= PHI_INIT;
          end else begin
            r_wdog <= w_event ? 32'd0 : r_wdog + 32'd1;
            if (w_event) begin
              r_zvs <= f_ramp(r_zvs, r_zvs_tgt);
              r_phi <= f_ramp(r_phi, r_phi_tgt);
            end
            if (w_hs) begin
              r_zvs_tgt <= f_clamp(i_ZVS_target);
              r_phi_tgt <= f_clamp(i_phi_target);
            end
          end
        end
        S_FAULT: begin
          if (i_fault_clear) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_ZVS          = r_zvs;
  assign o_phi          = r_phi;
  assign o_ctrl_resetn  = r_ctrl_resetn;
  assign o_locked       = w_locked;
  assign o_target_ready = w_locked;
  assign o_fault        = r_fault;
  assign o_state        = r_state;

endmodule
